apb_master_bridge: RTL and testbench

Upstream APB requester that drives the team's APB slave / register-file path. Accepts single read/write commands on a valid/ready interface and runs each as one APB4 transfer (SETUP then ACCESS, with wait states). Returns a response carrying read data and an error flag, including a bus-timeout error. One transfer is in flight at a time.

---
 rtl/apb_master_bridge.sv | 198 +++++++++++++++++++
 tb/tb_apb_master_bridge.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// APB4 requester: turns single valid/ready commands into one SETUP+ACCESS
// transfer each, with wait states and an optional PREADY timeout, and
// returns a held response (read data, error, timeout flag).
module apb_master_bridge #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned NBYTES         = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  // command channel
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [NBYTES-1:0]     cmd_strb,
  // response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  rsp_timeout,
  // APB4 requester port
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [NBYTES-1:0]     PSTRB,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR
);

  // Wait counter sized to hold TIMEOUT_CYCLES; one bit minimum when disabled.
  localparam int unsigned CNT_W =
    (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               TMO_EN    = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e                state_q,       state_d;
  logic                  cmd_ready_q,   cmd_ready_d;
  logic                  psel_q,        psel_d;
  logic                  penable_q,     penable_d;
  logic [ADDR_WIDTH-1:0] paddr_q,       paddr_d;
  logic                  pwrite_q,      pwrite_d;
  logic [NBYTES-1:0]     pstrb_q,       pstrb_d;
  logic [DATA_WIDTH-1:0] pwdata_q,      pwdata_d;
  logic                  rsp_valid_q,   rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q,   rsp_rdata_d;
  logic                  rsp_error_q,   rsp_error_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]      wait_cnt_q,    wait_cnt_d;
  logic [CNT_W-1:0]      wait_cnt_inc;

  // Next-state and registered-output decode.
  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pstrb_d       = pstrb_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_error_d   = rsp_error_q;
    rsp_timeout_d = rsp_timeout_q;
    wait_cnt_d    = wait_cnt_q;
    // Saturating increment: the counter never wraps back under the limit.
    wait_cnt_inc  = (wait_cnt_q == CNT_MAX) ? wait_cnt_q
                                            : wait_cnt_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d     = SETUP;
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          paddr_d     = cmd_addr;
          pwrite_d    = cmd_write;
          pwdata_d    = cmd_wdata;
          // Reads never carry strobes onto the bus.
          pstrb_d     = cmd_write ? cmd_strb : '0;
          wait_cnt_d  = '0;
        end else begin
          // First IDLE cycle after reset raises ready.
          cmd_ready_d = 1'b1;
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end

      ACCESS: begin
        if (PREADY) begin
          // Completion wins over a timeout landing in the same cycle.
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
          rsp_error_d   = PSLVERR;
          rsp_timeout_d = 1'b0;
        end else begin
          wait_cnt_d = wait_cnt_inc;
          if (TMO_EN && (wait_cnt_inc == CNT_LIMIT)) begin
            state_d       = RESP;
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_error_d   = 1'b1;
            rsp_timeout_d = 1'b1;
          end
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          pstrb_d     = '0;
        end
      end

      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b0;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops the bus immediately.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pstrb_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pstrb_q       <= pstrb_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_timeout = rsp_timeout_q;
  assign PSELx       = psel_q;
  assign PENABLE     = penable_q;
  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PSTRB       = pstrb_q;
  assign PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a small APB slave driver.
module tb_apb_master_bridge;

  logic        PCLK;
  logic        PRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        rsp_timeout;
  logic        PSELx;
  logic        PENABLE;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic [3:0]  PSTRB;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  int n_tests = 0;
  int n_fail  = 0;

  apb_master_bridge #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (32),
    .NBYTES        (4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_strb   (cmd_strb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error),
    .rsp_timeout(rsp_timeout),
    .PSELx      (PSELx),
    .PENABLE    (PENABLE),
    .PADDR      (PADDR),
    .PWRITE     (PWRITE),
    .PSTRB      (PSTRB),
    .PWDATA     (PWDATA),
    .PREADY     (PREADY),
    .PRDATA     (PRDATA),
    .PSLVERR    (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Global guard so a stuck run still ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample and drive 1ns after the edge.
  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // Issue one command from IDLE and play the slave: PREADY rises in ACCESS
  // cycle waits+1. Returns in RESP with the response captured.
  task automatic run_xfer(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input int waits, input logic [31:0] rd, input logic err,
                          output int acc, output logic [31:0] r_rdata,
                          output logic r_err, output logic r_tmo);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_strb  = strb;
    step();
    cmd_valid = 1'b0;
    check("setup_psel",    64'(PSELx),   64'(1));
    check("setup_penable", 64'(PENABLE), 64'(0));
    check("setup_paddr",   64'(PADDR),   64'(addr));
    check("setup_pwrite",  64'(PWRITE),  64'(wr));
    check("setup_pstrb",   64'(PSTRB),   64'(wr ? strb : 4'h0));
    check("setup_pwdata",  64'(PWDATA),  64'(wdata));
    check("setup_cmd_rdy", 64'(cmd_ready), 64'(0));
    step();
    acc = 0;
    while (PSELx && PENABLE && acc < 64) begin
      acc++;
      check("access_paddr", 64'(PADDR), 64'(addr));
      PREADY  = (acc > waits);
      PSLVERR = (acc > waits) ? err : 1'b1;
      PRDATA  = rd;
      step();
    end
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = 32'hFFFF_FFFF;
    check("resp_valid",   64'(rsp_valid), 64'(1));
    check("resp_psel",    64'(PSELx),     64'(0));
    check("resp_penable", 64'(PENABLE),   64'(0));
    r_rdata = rsp_rdata;
    r_err   = rsp_error;
    r_tmo   = rsp_timeout;
  endtask

  int          acc;
  logic [31:0] rd;
  logic        er;
  logic        to;

  initial begin
    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    rsp_ready = 1'b0;
    PREADY    = 1'b0;
    PRDATA    = '0;
    PSLVERR   = 1'b0;

    // Reset values
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    check("rst_psel",      64'(PSELx),     64'(0));
    check("rst_penable",   64'(PENABLE),   64'(0));
    check("rst_paddr",     64'(PADDR),     64'(0));
    check("rst_pstrb",     64'(PSTRB),     64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    PRESETn = 1'b1;
    step();
    check("idle_cmd_ready", 64'(cmd_ready), 64'(1));
    rsp_ready = 1'b1;

    // Write with one wait state
    run_xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 32'h5555_5555, 1'b0, acc, rd, er, to);
    check("wr_acc_cycles", 64'(acc), 64'(2));
    check("wr_rdata",      64'(rd),  64'(0));
    check("wr_err",        64'(er),  64'(0));
    check("wr_tmo",        64'(to),  64'(0));
    step();
    check("wr_idle_ready", 64'(cmd_ready), 64'(1));
    check("wr_idle_rspv",  64'(rsp_valid), 64'(0));
    check("wr_idle_pstrb", 64'(PSTRB),     64'(0));
    check("wr_idle_paddr", 64'(PADDR),     64'(32'h10));

    // Zero-wait read: 4 cycles accept to IDLE
    run_xfer(1'b0, 32'h24, 32'h0, 4'hF, 0, 32'h1234_5678, 1'b0, acc, rd, er, to);
    check("rd_acc_cycles", 64'(acc), 64'(1));
    check("rd_rdata",      64'(rd),  64'(32'h1234_5678));
    check("rd_err",        64'(er),  64'(0));
    step();
    check("rd_total_cycles", 64'(2 + acc + 1), 64'(4));
    check("rd_idle_ready",   64'(cmd_ready),   64'(1));

    // PREADY never comes: timeout after exactly 16 ACCESS cycles
    run_xfer(1'b0, 32'h30, 32'h0, 4'h0, 1000, 32'hAAAA_5555, 1'b0, acc, rd, er, to);
    check("tmo_acc_cycles", 64'(acc), 64'(16));
    check("tmo_rdata",      64'(rd),  64'(0));
    check("tmo_err",        64'(er),  64'(1));
    check("tmo_flag",       64'(to),  64'(1));
    step();

    // Slave error on a write
    run_xfer(1'b1, 32'h38, 32'h0000_00A5, 4'h1, 0, 32'h0, 1'b1, acc, rd, er, to);
    check("slverr_err",   64'(er), 64'(1));
    check("slverr_tmo",   64'(to), 64'(0));
    check("slverr_rdata", 64'(rd), 64'(0));
    step();

    // PREADY on the 16th ACCESS cycle beats the timeout
    run_xfer(1'b0, 32'h3C, 32'h0, 4'h0, 15, 32'hCAFE_F00D, 1'b0, acc, rd, er, to);
    check("edge_acc_cycles", 64'(acc), 64'(16));
    check("edge_err",        64'(er),  64'(0));
    check("edge_tmo",        64'(to),  64'(0));
    check("edge_rdata",      64'(rd),  64'(32'hCAFE_F00D));
    step();

    // Response backpressure with a new command waiting
    rsp_ready = 1'b0;
    run_xfer(1'b0, 32'h44, 32'h0, 4'h0, 0, 32'h0BAD_F00D, 1'b0, acc, rd, er, to);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h48;
    cmd_wdata = 32'h1122_3344;
    cmd_strb  = 4'h3;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_rsp_valid", 64'(rsp_valid), 64'(1));
      check("bp_rsp_rdata", 64'(rsp_rdata), 64'(32'h0BAD_F00D));
      check("bp_cmd_ready", 64'(cmd_ready), 64'(0));
      check("bp_psel",      64'(PSELx),     64'(0));
    end
    rsp_ready = 1'b1;
    step();
    check("bp_release_rspv", 64'(rsp_valid), 64'(0));
    check("bp_release_rdy",  64'(cmd_ready), 64'(1));
    check("bp_release_psel", 64'(PSELx),     64'(0));
    run_xfer(1'b1, 32'h48, 32'h1122_3344, 4'h3, 0, 32'h0, 1'b0, acc, rd, er, to);
    check("bp_second_err", 64'(er), 64'(0));
    step();

    // Reset in the middle of ACCESS
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h50;
    step();
    cmd_valid = 1'b0;
    step();
    check("mid_penable_pre", 64'(PENABLE), 64'(1));
    #2;
    PRESETn = 1'b0;
    #1;
    check("mid_psel_async",    64'(PSELx),   64'(0));
    check("mid_penable_async", 64'(PENABLE), 64'(0));
    repeat (2) step();
    check("mid_rsp_valid", 64'(rsp_valid), 64'(0));
    PRESETn = 1'b1;
    step();
    check("mid_after_ready", 64'(cmd_ready), 64'(1));
    check("mid_after_rspv",  64'(rsp_valid), 64'(0));
    run_xfer(1'b0, 32'h54, 32'h0, 4'h0, 0, 32'h0F0E_0D0C, 1'b0, acc, rd, er, to);
    check("mid_read_rdata", 64'(rd), 64'(32'h0F0E_0D0C));
    check("mid_read_err",   64'(er), 64'(0));
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
